ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 The block SHALL use clock clk (rising edge) and reset reset, synchronous, active-high; all state changes occur on clk rising edges only.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  pipeline clock
- reset  in  1  synchronous active-high reset
- start  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- rs_val  in  32  operand A (EX read data 1); dividend for DIV
- rt_val  in  32  operand B (EX read data 2); divisor for DIV
- hilo_read  in  1  EX-stage instruction is MFHI/MFLO
- mthi_we  in  1  write mt_data to HI
- mtlo_we  in  1  write mt_data to LO
- mt_data  in  32  MTHI/MTLO source
- hi_out  out  32  HI register
- lo_out  out  32  LO register
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- div_by_zero  out  1  one-cycle pulse with done: DIV/DIVU with rt_val == 0
- stall_req  out  1  freeze PC, IF/ID and ID/EX registers

Function
REQ-003 The FSM SHALL have states IDLE, RUN, FIX; reset enters IDLE.
REQ-004 In IDLE with start=1 the block SHALL latch op, take the magnitudes of rs_val/rt_val (signed ops only), record the result signs, load iteration counter 0, and enter RUN on the next edge.
REQ-005 RUN SHALL perform one iteration per cycle for exactly 32 cycles: shift-add for multiply, restoring shift-subtract for divide, on a 64-bit working register.
REQ-006 After the 32nd RUN cycle the FSM SHALL enter FIX for one cycle, apply two's-complement sign correction, write HI/LO at the end of FIX, and return to IDLE.
REQ-007 MULT/MULTU SHALL produce HI:LO = 64-bit product; signed result is negated when sign(rs)^sign(rt)=1.
REQ-008 DIV/DIVU SHALL produce LO = quotient, HI = remainder; quotient sign = sign(rs)^sign(rt), remainder sign = sign(rs); results truncate toward zero.
REQ-009 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-010 DIV/DIVU with rt_val==0 SHALL bypass RUN (IDLE->FIX), leave HI/LO unchanged, and pulse div_by_zero together with done.
REQ-011 Latency: start accepted at edge N; HI/LO valid and done=1 during the cycle after edge N+33 (divide-by-zero: after edge N+1).
REQ-012 busy SHALL be 1 in RUN and FIX, 0 in IDLE.
REQ-013 stall_req SHALL equal busy & (start | hilo_read), combinationally.
REQ-014 start while busy SHALL be ignored (no restart, operands not resampled).
REQ-015 mthi_we/mtlo_we SHALL write HI/LO at the next edge only in IDLE with start=0; ignored when busy or when start=1 in the same cycle.
REQ-016 hi_out/lo_out SHALL be driven directly from registers; no forwarding of in-flight results.
REQ-017 Counter SHALL be 6 bits, terminating at 31 without wrap into a second pass.

Reset
REQ-018 reset=1 SHALL set state IDLE and hi_out, lo_out, counter and working registers to 0, and busy, done, div_by_zero, stall_req to 0 at the next edge, aborting any operation in progress without updating HI/LO with partial results.

Verification
REQ-019 MULT rs=0xFFFFFFFE (-2), rt=0x00000003 -> after 34 cycles done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-020 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy high exactly 33 cycles.
REQ-021 DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> done+div_by_zero at N+1, HI/LO unchanged.
REQ-022 hilo_read=1 and second start asserted during RUN -> stall_req=1 each such cycle; second start ignored; stall_req=0 once done.
REQ-023 reset asserted at RUN cycle 10 -> next cycle busy=0, HI=LO=0; mthi_we with mt_data=0x12345678 in IDLE -> hi_out=0x12345678 next cycle; mthi_we with start same cycle -> HI unchanged.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage: 32-cycle shift-add
// multiply and restoring divide on a 64-bit working register, then a sign-fix cycle.
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hilo_read,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        stall_req
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic        is_div_q, is_div_d;
  logic        neg_q_q, neg_q_d;    // product / quotient sign
  logic        neg_r_q, neg_r_d;    // remainder sign
  logic        dz_q, dz_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;        // multiplicand or divisor magnitude
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dz_pulse_q, dz_pulse_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_rem, div_diff;
  logic [63:0] div_next;
  logic [63:0] prod_neg;
  logic [31:0] fix_hi, fix_lo;

  // Operand magnitudes; op[0]=1 marks the unsigned variants.
  assign a_neg = ~op[0] & rs_val[31];
  assign b_neg = ~op[0] & rt_val[31];
  assign a_mag = a_neg ? (~rs_val + 32'd1) : rs_val;
  assign b_mag = b_neg ? (~rt_val + 32'd1) : rt_val;

  // Shift-add: upper half accumulates, multiplier drains out of the low half.
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, dvs_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

  // Restoring divide: remainder in the upper half, quotient bits enter at bit 0.
  assign div_rem  = acc_q[63:31];
  assign div_diff = div_rem - {1'b0, dvs_q};
  assign div_next = div_diff[32] ? {div_rem[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  assign prod_neg = ~acc_q + 64'd1;

  always_comb begin
    fix_hi = acc_q[63:32];
    fix_lo = acc_q[31:0];
    if (is_div_q) begin
      if (neg_q_q) fix_lo = ~acc_q[31:0] + 32'd1;
      if (neg_r_q) fix_hi = ~acc_q[63:32] + 32'd1;
    end else if (neg_q_q) begin
      fix_hi = prod_neg[63:32];
      fix_lo = prod_neg[31:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    dz_d       = dz_q;
    acc_d      = acc_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dz_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = op[1];
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          dz_d     = op[1] & (rt_val == 32'd0);
          acc_d    = {32'd0, a_mag};
          dvs_d    = b_mag;
          cnt_d    = 6'd0;
          state_d  = (op[1] && rt_val == 32'd0) ? FIX : RUN;
        end else begin
          if (mthi_we) hi_d = mt_data;
          if (mtlo_we) lo_d = mt_data;
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == 6'd31) state_d = FIX;
        else                cnt_d   = cnt_q + 6'd1;
      end
      FIX: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        dz_pulse_d = dz_q;
        if (!dz_q) begin
          hi_d = fix_hi;
          lo_d = fix_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dz_q       <= 1'b0;
      acc_q      <= 64'd0;
      dvs_q      <= 32'd0;
      cnt_q      <= 6'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      dz_q       <= dz_d;
      acc_q      <= acc_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dz_pulse_q <= dz_pulse_d;
    end
  end

  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_pulse_q;
  assign stall_req   = busy & (start | hilo_read);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed HI/LO results, latency,
// busy width, stall behaviour, reset abort and MTHI/MTLO gating.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, hilo_read, mthi_we, mtlo_we;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, mt_data;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_by_zero, stall_req;

  int checks = 0;
  int failures = 0;

  ex_muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .hilo_read(hilo_read), .mthi_we(mthi_we),
    .mtlo_we(mtlo_we), .mt_data(mt_data), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; lat counts edges after the accepting edge.
  task automatic wait_done(output int lat, output int bcnt, output logic dz);
    lat = 0;
    bcnt = 0;
    dz = 1'b0;
    while (!done && lat < 60) begin
      step();
      lat++;
      if (busy) bcnt++;
    end
    dz = div_by_zero;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt, output logic dz);
    int l, bc;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    step();
    start = 1'b0;
    wait_done(l, bc, dz);
    lat = l;
    bcnt = bc + (busy ? 0 : 0);
    bcnt = bc;
  endtask

  int lat, bcnt;
  logic dz;

  initial begin
    reset = 1'b1; start = 1'b0; hilo_read = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    op = 2'b00; rs_val = '0; rt_val = '0; mt_data = '0;
    step(); step();
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall_req, 0);
    reset = 1'b0;
    step();

    // MULT -2 * 3; busy is sampled after the accepting edge too
    start = 1'b1; op = 2'b00; rs_val = 32'hFFFF_FFFE; rt_val = 32'h3;
    step();
    start = 1'b0;
    chk("mult_busy_n", busy, 1);
    wait_done(lat, bcnt, dz);
    chk("mult_lat", lat, 33);
    chk("mult_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mult_dz", dz, 0);

    // MULTU max*max, busy exactly 33 cycles (1 after edge N + 32 counted)
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, dz);
    chk("multu_hilo", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
    chk("multu_busy", bcnt + 1, 33);
    chk("multu_lat", lat, 33);

    run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, lat, bcnt, dz);
    chk("mult_ext", {hi_out, lo_out}, 64'hC000_0000_8000_0000);

    // DIV -7 / 2
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2, lat, bcnt, dz);
    chk("div_neg", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_lat", lat, 33);

    // DIVU 7 / 0 -> quick done, HI/LO unchanged
    run_op(2'b11, 32'h7, 32'h0, lat, bcnt, dz);
    chk("dz_lat", lat, 1);
    chk("dz_flag", dz, 1);
    chk("dz_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    step();
    chk("dz_pulse_end", {done, div_by_zero}, 0);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, dz);
    chk("div_ovf", {hi_out, lo_out}, 64'h0000_0000_8000_0000);

    run_op(2'b10, 32'h7, 32'hFFFF_FFFE, lat, bcnt, dz);
    chk("div_negdiv", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFD);

    run_op(2'b11, 32'd100, 32'd7, lat, bcnt, dz);
    chk("divu", {hi_out, lo_out}, {32'd2, 32'd14});

    // stall_req during RUN; second start ignored
    start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd5;
    step();
    start = 1'b0;
    repeat (5) step();
    hilo_read = 1'b1; #1;
    chk("stall_hilo", stall_req, 1);
    hilo_read = 1'b0; #1;
    chk("stall_idle_req", stall_req, 0);
    start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; #1;
    chk("stall_start", stall_req, 1);
    step();
    chk("stall_start2", stall_req, 1);
    start = 1'b0;
    wait_done(lat, bcnt, dz);
    chk("ign_start_hilo", {hi_out, lo_out}, 64'd15);
    hilo_read = 1'b1; #1;
    chk("stall_after_done", stall_req, 0);
    hilo_read = 1'b0;
    step();
    chk("no_restart", busy, 0);

    // reset at RUN cycle 10 aborts
    start = 1'b1; op = 2'b00; rs_val = 32'd9; rt_val = 32'd9;
    step();
    start = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi_out, lo_out}, 0);
    step();
    chk("abort_done", done, 0);

    // MTHI/MTLO in IDLE
    mthi_we = 1'b1; mt_data = 32'h1234_5678;
    step();
    mthi_we = 1'b0;
    chk("mthi", hi_out, 32'h1234_5678);
    mtlo_we = 1'b1; mt_data = 32'hCAFE_0001;
    step();
    mtlo_we = 1'b0;
    chk("mtlo", lo_out, 32'hCAFE_0001);

    // MTHI together with start is dropped; MTHI while busy also dropped
    mthi_we = 1'b1; mt_data = 32'hDEAD_BEEF; start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3;
    step();
    start = 1'b0;
    chk("mthi_w_start", hi_out, 32'h1234_5678);
    step();
    chk("mthi_busy", hi_out, 32'h1234_5678);
    mthi_we = 1'b0;
    wait_done(lat, bcnt, dz);
    chk("mul_after_mt", {hi_out, lo_out}, 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
